// File: rtl/coi2_conv_ctrl.sv
// coi2_conv_ctrl: conversion sequencer for a second-order cascade-of-integrators decimator
module coi2_conv_ctrl #(
  parameter int OSR_W    = 16,
  parameter int DW       = 32,
  parameter int PIPE_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_adc,
  input  logic             start,
  input  logic             cont,
  input  logic             stop,
  input  logic             abort,
  input  logic [OSR_W-1:0] cfg_osr,
  input  logic [OSR_W-1:0] cfg_settle,
  input  logic [DW-1:0]    filt_dout,
  output logic             mod_en,
  output logic             filt_clr,
  output logic             busy,
  output logic [DW-1:0]    res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             overrun,
  output logic             cfg_err,
  output logic [CNT_W-1:0] conv_cnt
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_CLEAR  = 3'd2;
  localparam logic [2:0] S_INTEG  = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [OSR_W-1:0] ONE        = OSR_W'(1);
  localparam logic [OSR_W-1:0] TWO        = OSR_W'(2);
  localparam logic [OSR_W-1:0] DRAIN_LAST = OSR_W'(PIPE_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [2:0]       r_state, w_next;
  logic [OSR_W-1:0] r_cnt, r_osr, r_settle;
  logic             r_cont, r_stop;
  logic [DW-1:0]    r_res_data;
  logic             r_res_valid, r_overrun, r_cfg_err;
  logic [CNT_W-1:0] r_conv_cnt;
  logic             w_accept, w_last, w_cap;

  assign w_accept  = r_state == S_IDLE && start && cfg_osr >= TWO && !abort;
  assign w_last    = (r_state == S_SETTLE && r_cnt == r_settle - ONE) ||
                     (r_state == S_INTEG  && r_cnt == r_osr - ONE) ||
                     (r_state == S_DRAIN  && r_cnt == DRAIN_LAST);
  assign w_cap     = r_state == S_DRAIN && w_last && !abort;
  assign mod_en    = r_state == S_SETTLE || r_state == S_CLEAR || r_state == S_INTEG;
  assign filt_clr  = r_state == S_CLEAR;
  assign busy      = r_state != S_IDLE;
  assign res_data  = r_res_data;
  assign res_valid = r_res_valid;
  assign overrun   = r_overrun;
  assign cfg_err   = r_cfg_err;
  assign conv_cnt  = r_conv_cnt;

  // next-state decode; abort overrides everything, a stop seen this cycle also ends continuous mode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_accept ? (cfg_settle == '0 ? S_CLEAR : S_SETTLE) : S_IDLE;
      S_SETTLE: w_next = w_last ? S_CLEAR : S_SETTLE;
      S_CLEAR:  w_next = S_INTEG;
      S_INTEG:  w_next = w_last ? S_DRAIN : S_INTEG;
      S_DRAIN:  w_next = w_last ? ((r_cont && !(r_stop || stop)) ? S_CLEAR : S_IDLE) : S_DRAIN;
      default:  w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  // state, per-phase cycle counter, latched configuration and the sticky stop request
  always_ff @(posedge clk or posedge rst_adc) begin
    if (rst_adc) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_osr    <= '0;
      r_settle <= '0;
      r_cont   <= 1'b0;
      r_stop   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next == r_state && r_state != S_IDLE) ? r_cnt + ONE : '0;
      r_stop  <= !(abort || r_state == S_IDLE) && (r_stop || stop);
      if (w_accept) begin
        r_osr    <= cfg_osr;
        r_settle <= cfg_settle;
        r_cont   <= cont;
      end
    end
  end

  // result capture with valid/ready handshake, overrun flag, conversion count and config error pulse
  always_ff @(posedge clk or posedge rst_adc) begin
    if (rst_adc) begin
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_conv_cnt  <= '0;
    end else begin
      r_cfg_err <= r_state == S_IDLE && start && cfg_osr < TWO && !abort;
      if (w_cap) begin
        r_conv_cnt <= r_conv_cnt + CNT_ONE;
        if (!r_res_valid || res_ready) begin
          r_res_data  <= filt_dout;
          r_res_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/coi2_conv_ctrl.md
Name: coi2_conv_ctrl

Overview:
Conversion sequencer for the second-order cascade-of-integrators decimation filter that follows the 1-bit sigma-delta modulator.
- Gates the modulator, issues the filter clear and counts the oversampling window.
- Captures the filter output after the pipeline drain and hands the result to the readout logic over a valid/ready handshake.
- Supports single-shot and continuous conversion.

Parameters:
OSR_W, 16, width of oversampling-ratio and settle counters
DW, 32, filter output / result width
PIPE_LAT, 2, cycles from last integration cycle to filt_dout capture (filter int2->dout register alignment)
CNT_W, 16, width of conversion counter

Ports:
clk  input  1  system clock, one modulator bit per cycle
rst_adc  input  1  asynchronous, active-high reset
start  input  1  request conversion (level or pulse, sampled in IDLE)
cont  input  1  continuous mode, latched at start
stop  input  1  end continuous mode after current conversion
abort  input  1  immediate return to IDLE, result discarded
cfg_osr  input  OSR_W  oversampling ratio, latched at start
cfg_settle  input  OSR_W  modulator warm-up cycles before clear, latched at start
filt_dout  input  DW  filter output
mod_en  output  1  modulator / filter input enable
filt_clr  output  1  one-cycle synchronous clear to filter integrators
busy  output  1  high in any state except IDLE
res_data  output  DW  captured result
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
overrun  output  1  sticky: result dropped because res_valid was still pending
cfg_err  output  1  one-cycle pulse: start rejected
conv_cnt  output  CNT_W  completed conversions, wraps at 2^CNT_W

Behaviour:
- Reset (rst_adc high, asynchronous):
  - state IDLE.
  - mod_en, filt_clr, busy, res_valid, overrun and cfg_err all 0.
  - res_data and conv_cnt 0.
- States: IDLE, SETTLE, CLEAR, INTEG, DRAIN.
- IDLE:
  - start=1 with cfg_osr>=2: latch cfg_osr, cfg_settle and cont; next state SETTLE, or CLEAR if cfg_settle=0.
  - start=1 with cfg_osr<2: cfg_err=1 for one cycle; stay in IDLE.
- SETTLE: mod_en=1 for exactly cfg_settle cycles, then CLEAR.
- CLEAR: exactly one cycle with filt_clr=1 and mod_en=1; the bit in this cycle is discarded by the clear. Next state INTEG.
- INTEG: mod_en=1 for exactly cfg_osr cycles (counter 0..osr-1), then DRAIN.
- DRAIN:
  - mod_en=0 for PIPE_LAT cycles.
  - On the last DRAIN cycle, sample filt_dout and increment conv_cnt.
  - Next state: CLEAR if cont_latched=1 and stop has not been seen since start; otherwise IDLE.
- stop: may arrive in any state; it is registered and takes effect at the end of the current DRAIN. It has no effect in single-shot mode.
- abort (highest priority): next cycle state IDLE, mod_en=0, filt_clr=0, no capture, conv_cnt unchanged, stop flag cleared. A pending res_valid is kept.
- Result handshake:
  - At capture, if res_valid=0 or res_ready=1 in the same cycle: res_data<=filt_dout and res_valid<=1.
  - Otherwise: keep the old res_data, set overrun=1 and drop the new result.
  - res_valid clears on res_valid&res_ready when no capture occurs in that cycle.
  - overrun clears only on rst_adc.
- Timing: a single-shot conversion takes cfg_settle+1+cfg_osr+PIPE_LAT cycles from the cycle after start acceptance until res_valid rises.
- Start is ignored while busy=1.
- Counters use OSR_W-bit compares; cfg_osr=2^OSR_W-1 is legal.

Test Plan:
- Reset value check: assert rst_adc mid-INTEG -> all outputs 0 and state IDLE within the same cycle, asynchronously; on release, no spurious filt_clr.
- Single shot, behavioural CoI2 model with synchronous clear, din all ones:
  - cfg_osr=4, cfg_settle=0 -> one filt_clr pulse, mod_en high 5 cycles, res_valid after 7 cycles, res_data=6, conv_cnt=1.
  - Same stimulus with cfg_osr=256 -> res_data=32640.
- Settle plus config error:
  - cfg_settle=3, cfg_osr=4 -> mod_en high 3 cycles before filt_clr.
  - start with cfg_osr=1 -> cfg_err single pulse, busy stays 0.
- Continuous mode, cfg_osr=8, res_ready held 1:
  - Consecutive results spaced 1+8+2=11 cycles apart.
  - stop asserted mid-INTEG of the third conversion -> exactly 3 results, then IDLE.
- Overrun: continuous mode, res_ready=0 -> first result retained, overrun=1 at second capture, conv_cnt=2.
- Abort: abort in SETTLE, INTEG and DRAIN -> IDLE next cycle, mod_en=0, no res_valid, conv_cnt unchanged; start the cycle after abort is accepted normally.
